// File: rtl/uart_to_ebi.sv
// uart_to_ebi: serial host bridge onto a 16-bit external bus interface.
// Frames: write 0xAB,AH,AL,DH,DL,CRC; read 0xAA,AH,AL,CRC -> reply 0xAA,RH,RL,CRC.
// Ports:
//   clk, rst (async, active-high), prescale (bit period = 8*prescale clk)
//   rxd/txd         8N1 serial pair, idle high
//   ebi_cs/rden/wren, ebi_addr, ebi_dout, ebi_din   bus side, 1-cycle read latency
//   tx_busy, rx_busy, rx_overrun_error, rx_frame_error   status, errors are pulses
module uart_to_ebi (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] prescale,
    input  logic        rxd,
    output logic        txd,
    output logic        ebi_cs,
    output logic        ebi_rden,
    output logic        ebi_wren,
    output logic [15:0] ebi_addr,
    input  logic [15:0] ebi_din,
    output logic [15:0] ebi_dout,
    output logic        tx_busy,
    output logic        rx_busy,
    output logic        rx_overrun_error,
    output logic        rx_frame_error
);

    localparam logic [7:0] CRC_INIT = 8'h14;
    localparam logic [7:0] HDR_RD   = 8'hAA;
    localparam logic [7:0] HDR_WR   = 8'hAB;

    // CRC-8 poly 0x07, MSB first, byte folded in before shifting
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
        return x;
    endfunction

    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_ADDR_H = 3'd1,
        P_ADDR_L = 3'd2,
        P_DATA_H = 3'd3,
        P_DATA_L = 3'd4,
        P_CRC    = 3'd5
    } p_state_t;

    typedef enum logic [2:0] {
        E_IDLE = 3'd0,
        E_WRITE = 3'd1,
        E_READ = 3'd2,
        E_CAP = 3'd3,
        E_RESP = 3'd4
    } e_state_t;

    logic [18:0] per_m1;
    logic [18:0] half_m1;
    assign per_m1  = {prescale, 3'b000} - 19'd1;
    assign half_m1 = {1'b0, prescale, 2'b00} - 19'd1;

    // ---------------- receiver ----------------
    logic [1:0]  rx_sync;
    logic        rxs;
    logic [18:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        consume;
    logic        pend;

    assign rxs     = rx_sync[1];
    assign consume = rx_valid && !pend;

    // rx_bit 0 = start-bit validation, 1..8 data, 9 stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync          <= 2'b11;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_sh            <= '0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            rx_busy          <= 1'b0;
            rx_frame_error   <= 1'b0;
            rx_overrun_error <= 1'b0;
        end else begin
            rx_sync          <= {rx_sync[0], rxd};
            rx_frame_error   <= 1'b0;
            rx_overrun_error <= 1'b0;
            if (consume)
                rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (!rxs) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == half_m1) begin
                    rx_cnt <= '0;
                    if (rxs)
                        rx_busy <= 1'b0;
                    else
                        rx_bit <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + 19'd1;
                end
            end else if (rx_cnt == per_m1) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (!rxs) begin
                        rx_frame_error <= 1'b1;
                    end else if (rx_valid && !consume) begin
                        rx_overrun_error <= 1'b1;
                    end else begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                    end
                end else begin
                    rx_sh  <= {rxs, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 19'd1;
            end
        end
    end

    // ---------------- transmitter ----------------
    logic [18:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_sh;
    logic        tx_go;
    logic [7:0]  tx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (tx_go) begin
                tx_busy <= 1'b1;
                txd     <= 1'b0;
                tx_sh   <= {1'b1, tx_byte};
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end
        end else if (tx_cnt == per_m1) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                txd    <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 19'd1;
        end
    end

    // ---------------- frame parser ----------------
    p_state_t    p_state, p_next;
    e_state_t    e_state, e_next;
    logic        p_wr;
    logic [15:0] p_addr;
    logic [15:0] p_data;
    logic [7:0]  p_crc;
    logic [23:0] gap_cnt;
    logic        gap_to;
    logic        launch;

    assign gap_to = gap_cnt > {prescale, 8'h00};
    assign launch = pend && (e_state == E_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            p_state <= P_IDLE;
        else
            p_state <= p_next;
    end

    // An accepted frame parks in P_CRC with pend set until the bus side is free
    always_comb begin
        p_next = p_state;
        if (pend) begin
            if (launch)
                p_next = P_IDLE;
        end else if (rx_frame_error || gap_to) begin
            p_next = P_IDLE;
        end else if (consume) begin
            unique case (p_state)
                P_IDLE:   if (rx_data == HDR_RD || rx_data == HDR_WR)
                              p_next = P_ADDR_H;
                P_ADDR_H: p_next = P_ADDR_L;
                P_ADDR_L: p_next = p_wr ? P_DATA_H : P_CRC;
                P_DATA_H: p_next = P_DATA_L;
                P_DATA_L: p_next = P_CRC;
                P_CRC:    if (rx_data != p_crc)
                              p_next = P_IDLE;
                default:  p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            p_wr    <= 1'b0;
            p_addr  <= '0;
            p_data  <= '0;
            p_crc   <= CRC_INIT;
            gap_cnt <= '0;
        end else begin
            if (p_state == P_IDLE || pend || consume)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + 24'd1;
            if (launch)
                pend <= 1'b0;
            if (consume) begin
                p_crc <= (p_state == P_IDLE) ? crc8(CRC_INIT, rx_data)
                                             : crc8(p_crc, rx_data);
                case (p_state)
                    P_IDLE:   p_wr <= (rx_data == HDR_WR);
                    P_ADDR_H: p_addr[15:8] <= rx_data;
                    P_ADDR_L: p_addr[7:0] <= rx_data;
                    P_DATA_H: p_data[15:8] <= rx_data;
                    P_DATA_L: p_data[7:0] <= rx_data;
                    P_CRC:    if (rx_data == p_crc && !rx_frame_error && !gap_to)
                                  pend <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    // ---------------- bus sequencer ----------------
    logic [15:0] rdata;
    logic [1:0]  idx;
    logic [7:0]  resp_crc;

    assign resp_crc = crc8(crc8(crc8(CRC_INIT, HDR_RD), rdata[15:8]), rdata[7:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            e_state <= E_IDLE;
        else
            e_state <= e_next;
    end

    always_comb begin
        e_next = e_state;
        unique case (e_state)
            E_IDLE:  if (pend)
                         e_next = p_wr ? E_WRITE : E_READ;
            E_WRITE: e_next = E_IDLE;
            E_READ:  e_next = E_CAP;
            E_CAP:   e_next = E_RESP;
            E_RESP:  if (tx_go && idx == 2'd3)
                         e_next = E_IDLE;
            default: e_next = E_IDLE;
        endcase
    end

    always_comb begin
        ebi_wren = (e_state == E_WRITE);
        ebi_rden = (e_state == E_READ);
        ebi_cs   = ebi_wren || ebi_rden;
        tx_go    = (e_state == E_RESP) && !tx_busy;
        unique case (idx)
            2'd0:    tx_byte = HDR_RD;
            2'd1:    tx_byte = rdata[15:8];
            2'd2:    tx_byte = rdata[7:0];
            default: tx_byte = resp_crc;
        endcase
    end

    // Read data is taken one cycle after the strobe cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ebi_addr <= '0;
            ebi_dout <= '0;
            rdata    <= '0;
            idx      <= '0;
        end else begin
            if (launch) begin
                ebi_addr <= p_addr;
                if (p_wr)
                    ebi_dout <= p_data;
            end
            if (e_state == E_CAP) begin
                rdata <= ebi_din;
                idx   <= '0;
            end
            if (tx_go)
                idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_uart_to_ebi.sv
// Directed bench for uart_to_ebi at prescale=13.
// A sender thread drives host frames; a checker thread consumes logged bus cycles and reply bytes.
module tb_uart_to_ebi;

    localparam int BP = 104;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic        rxd;
    logic        txd;
    logic        ebi_cs;
    logic        ebi_rden;
    logic        ebi_wren;
    logic [15:0] ebi_addr;
    logic [15:0] ebi_din;
    logic [15:0] ebi_dout;
    logic        tx_busy;
    logic        rx_busy;
    logic        rx_overrun_error;
    logic        rx_frame_error;

    always #5 clk = ~clk;

    uart_to_ebi dut (
        .clk(clk),
        .rst(rst),
        .prescale(prescale),
        .rxd(rxd),
        .txd(txd),
        .ebi_cs(ebi_cs),
        .ebi_rden(ebi_rden),
        .ebi_wren(ebi_wren),
        .ebi_addr(ebi_addr),
        .ebi_din(ebi_din),
        .ebi_dout(ebi_dout),
        .tx_busy(tx_busy),
        .rx_busy(rx_busy),
        .rx_overrun_error(rx_overrun_error),
        .rx_frame_error(rx_frame_error)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bitwise CRC-8 (poly 0x07, init supplied by caller)
    function automatic logic [7:0] crc_add(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // bus-cycle log
    logic        ev_wr[0:31];
    logic [15:0] ev_a[0:31];
    logic [15:0] ev_d[0:31];
    int          ev_n = 0;
    int          ev_rd = 0;
    int          viol = 0;
    int          rxerr = 0;
    logic        cs_prev = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ebi_rden && ebi_wren) viol++;
            if (ebi_cs != (ebi_rden || ebi_wren)) viol++;
            if (ebi_cs && cs_prev) viol++;
            if (rx_frame_error || rx_overrun_error) rxerr++;
            if (ebi_cs && ev_n < 32) begin
                ev_wr[ev_n] = ebi_wren;
                ev_a[ev_n]  = ebi_addr;
                ev_d[ev_n]  = ebi_dout;
                ev_n++;
            end
        end
        cs_prev = ebi_cs;
    end

    // reply-byte log from txd
    logic [7:0] tq[0:63];
    int         tq_n = 0;
    int         tq_rd = 0;
    int         stop_bad = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                repeat (BP / 2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BP) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (BP) @(negedge clk);
                    if (txd !== 1'b1) stop_bad++;
                    if (tq_n < 64) begin
                        tq[tq_n] = b;
                        tq_n++;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rxd = 1'b0;
        repeat (BP) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BP) @(posedge clk);
        end
        rxd = 1'b1;
        repeat (BP + 2) @(posedge clk);
    endtask

    task automatic send_wr(input logic [15:0] a, input logic [15:0] d, input logic bad);
        logic [7:0] f[5];
        logic [7:0] c;
        f = '{8'hAB, a[15:8], a[7:0], d[15:8], d[7:0]};
        c = 8'h14;
        for (int i = 0; i < 5; i++) begin
            c = crc_add(c, f[i]);
            send_byte(f[i]);
        end
        send_byte(bad ? (c ^ 8'h01) : c);
    endtask

    task automatic send_rd(input logic [15:0] a);
        logic [7:0] f[3];
        logic [7:0] c;
        f = '{8'hAA, a[15:8], a[7:0]};
        c = 8'h14;
        for (int i = 0; i < 3; i++) begin
            c = crc_add(c, f[i]);
            send_byte(f[i]);
        end
        send_byte(c);
    endtask

    task automatic expect_ev(input string tag, input logic wr,
                             input logic [15:0] a, input logic [15:0] d);
        int k;
        k = 0;
        while (ev_n <= ev_rd && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(ev_n > ev_rd), 1);
        if (ev_n > ev_rd) begin
            chk({tag, "_kind"}, ev_wr[ev_rd], wr);
            chk({tag, "_addr"}, ev_a[ev_rd], a);
            if (wr)
                chk({tag, "_dout"}, ev_d[ev_rd], d);
            ev_rd++;
        end
    endtask

    // ebi_din is 0xABAB throughout, so every reply is AA AB AB 11
    task automatic expect_reply(input string tag);
        logic [7:0] e[4];
        int k;
        e = '{8'hAA, 8'hAB, 8'hAB, 8'h11};
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (tq_n <= tq_rd && k < 3000) begin
                @(negedge clk);
                k++;
            end
            chk({tag, "_byte_seen"}, 32'(tq_n > tq_rd), 1);
            if (tq_n > tq_rd) begin
                chk($sformatf("%s_byte%0d", tag, i), tq[tq_rd], e[i]);
                tq_rd++;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        rxd      = 1'b1;
        prescale = 16'd13;
        ebi_din  = 16'hABAB;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_cs", ebi_cs, 0);
        chk("rst_strobes", {ebi_rden, ebi_wren}, 0);
        chk("rst_addr", ebi_addr, 0);
        chk("rst_dout", ebi_dout, 0);
        chk("rst_busy", {tx_busy, rx_busy}, 0);
        chk("rst_err", {rx_overrun_error, rx_frame_error}, 0);
        chk("rst_p_state", dut.p_state, 0);
        chk("rst_e_state", dut.e_state, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        fork
            begin
                send_wr(16'h1234, 16'h5678, 1'b0);
                send_rd(16'hAAAA);
                send_wr(16'h0001, 16'h1111, 1'b0);
                send_rd(16'h0011);
                send_rd(16'h0012);
                send_wr(16'h0002, 16'h2222, 1'b0);
                send_wr(16'h0003, 16'h3333, 1'b0);
                send_rd(16'h0013);
                send_rd(16'h0014);
                send_rd(16'h0015);
                send_wr(16'h0004, 16'h4444, 1'b1);
                send_wr(16'h0005, 16'h5555, 1'b0);
                send_byte(8'h55);
                send_rd(16'h0020);
                send_byte(8'hAB);
                send_byte(8'h00);
                send_byte(8'h07);
                repeat (4000) @(posedge clk);
                send_wr(16'h0006, 16'h6666, 1'b0);
            end
            begin
                expect_ev("t1_wr", 1'b1, 16'h1234, 16'h5678);
                repeat (5) @(negedge clk);
                chk("t1_addr_held", ebi_addr, 16'h1234);
                chk("t1_dout_held", ebi_dout, 16'h5678);
                chk("t1_no_reply", tq_n, 0);
                chk("t1_txd_idle", txd, 1);
                expect_ev("t2_rd", 1'b0, 16'hAAAA, 16'h0000);
                expect_reply("t2");
                expect_ev("t3_w1", 1'b1, 16'h0001, 16'h1111);
                expect_ev("t3_r11", 1'b0, 16'h0011, 16'h0000);
                expect_reply("t3_r11");
                expect_ev("t3_r12", 1'b0, 16'h0012, 16'h0000);
                expect_reply("t3_r12");
                expect_ev("t3_w2", 1'b1, 16'h0002, 16'h2222);
                expect_ev("t3_w3", 1'b1, 16'h0003, 16'h3333);
                expect_ev("t3_r13", 1'b0, 16'h0013, 16'h0000);
                expect_reply("t3_r13");
                expect_ev("t3_r14", 1'b0, 16'h0014, 16'h0000);
                expect_reply("t3_r14");
                expect_ev("t3_r15", 1'b0, 16'h0015, 16'h0000);
                expect_reply("t3_r15");
                expect_ev("t4_wr", 1'b1, 16'h0005, 16'h5555);
                expect_ev("t5_rd", 1'b0, 16'h0020, 16'h0000);
                expect_reply("t5");
                expect_ev("t6_wr", 1'b1, 16'h0006, 16'h6666);
            end
        join

        repeat (50) @(negedge clk);
        chk("total_bus_cycles", ev_n, 13);
        chk("total_reply_bytes", tq_n, 28);
        chk("strobe_rules", viol, 0);
        chk("rx_err_pulses", rxerr, 0);
        chk("tx_stop_bits", stop_bad, 0);
        chk("end_p_state", dut.p_state, 0);
        chk("end_e_state", dut.e_state, 0);
        chk("end_txd", txd, 1);

        send_byte(8'hAB);
        rxd = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("mid_p_state", dut.p_state, 1);
        chk("mid_rx_busy", rx_busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_p_state", dut.p_state, 0);
        chk("arst_rx_busy", rx_busy, 0);
        chk("arst_txd", txd, 1);
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_to_ebi.md
# uart_to_ebi

UART-to-EBI bridge: a host on a serial line reads and writes a 16-bit-address, 16-bit-data external bus interface (EBI) using short CRC-protected byte frames. It contains an 8N1 UART receiver and transmitter, a frame parser with CRC-8 check, an EBI sequencer and a response framer. It sits between a board-level UART pin pair and an on-chip register/memory bus.

## Interface
- No parameters. Data width 8 (UART) and 16 (EBI) are fixed.
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- prescale  in  16  baud divider: bit period = 8*prescale clk cycles
- rxd  in  1  serial input, idle high
- txd  out  1  serial output, idle high
- ebi_cs  out  1  bus cycle strobe
- ebi_rden  out  1  read strobe
- ebi_wren  out  1  write strobe
- ebi_addr  out  16  bus address
- ebi_din  in  16  read data from bus
- ebi_dout  out  16  write data to bus
- tx_busy  out  1  transmitter shifting a byte
- rx_busy  out  1  receiver inside a character
- rx_overrun_error  out  1  one-cycle pulse, received byte lost
- rx_frame_error  out  1  one-cycle pulse, stop bit sampled low

## Operation
- UART: 8 data bits, LSB first, no parity, 1 stop bit. RX samples mid-bit (start bit validated at 4*prescale). TX: start 0, 8 data, stop 1.
- CRC: CRC-8, polynomial x^8+x^2+x+1 (0x07), MSB-first, init 0x14, no reflection, no final XOR; next = f(crc XOR byte).
- Write frame (host->bridge): 0xAB, A[15:8], A[7:0], D[15:8], D[7:0], CRC over first 5 bytes. No response.
- Read frame: 0xAA, A[15:8], A[7:0], CRC over first 3 bytes. Response: 0xAA, R[15:8], R[7:0], CRC over those 3 bytes (init 0x14).
- Parser states: IDLE(0), ADDR_H, ADDR_L, DATA_H, DATA_L, CRC. In IDLE any byte other than 0xAA/0xAB is dropped. Read frames skip DATA states.
- CRC mismatch: frame discarded silently, no bus cycle, no response, back to IDLE.
- Received byte with frame error: discarded, parser back to IDLE.
- Inter-byte gap > 256*prescale clk cycles inside a frame: partial frame aborted, IDLE.
- EBI states: IDLE(0), WRITE, READ, READ_CAPTURE, RESP. Both parser and EBI state encode IDLE as 0.
- Bytes arriving while a read response is still transmitting are parsed normally; a new command is executed only after the EBI FSM returns to IDLE (parser holds in CRC-accepted state until then).

## Timing
- Reset values: txd=1, ebi_cs=ebi_rden=ebi_wren=0, ebi_addr=0, ebi_dout=0, busy/error outputs 0, both FSMs IDLE.
- Write: cycle after CRC byte accepted, ebi_cs=ebi_wren=1 for exactly 1 clk with ebi_addr/ebi_dout valid; addr/dout held until next command.
- Read: cycle after CRC accepted, ebi_cs=ebi_rden=1 for 1 clk; ebi_din sampled on the following clk edge (1-cycle read latency).
- Response bytes queued back-to-back; first start bit within 2 clk of capture; no idle gap between response characters beyond TX stop bit.
- ebi_rden and ebi_wren never high simultaneously; ebi_cs high only with one of them.
- rst asserted mid-frame or mid-transmit: all state lost immediately, txd returns high.

## Test plan
- prescale=13, write 0x1234<-0x5678 with valid CRC -> one-cycle ebi_cs&ebi_wren, ebi_addr=0x1234, ebi_dout=0x5678; txd stays idle.
- ebi_din=0xABAB, read addr 0xAAAA -> one-cycle ebi_cs&ebi_rden at 0xAAAA; reply bytes 0xAA,0xAB,0xAB,0x11.
- Interleaved sequence: write 0x0001, reads 0x0011/0x0012, writes 0x0002/0x0003, reads 0x0013..0x0015 -> each bus cycle once, in order, each reply CRC valid, data 0xABAB; both FSMs end IDLE.
- Write frame with corrupted CRC -> no EBI strobe, no reply; next valid frame executes normally.
- Stray byte 0x55 then valid read -> 0x55 ignored, read executes and replies.
- Truncated frame (3 bytes) then gap > 256*prescale, then valid write -> partial frame aborted, write executes once.
